// File: rtl/fpnew_fsm_share_arbiter.sv
// fpnew_fsm_share_arbiter
// Shares one iterative start/kill/ready lane (e.g. a DIVSQRT unit) between
// NumReq requesters. A round-robin arbiter grants one operation at a time; the
// result handshake is routed back to the requester that owns the operation.
// Requesters can flush their own operation, and a watchdog kills a lane that
// never reports ready, returning a response flagged as timed out.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   req_valid_i     request valid per requester
//   req_ready_o     request accepted (one-hot or zero)
//   req_tag_i       per-requester tags, requester r in slice r
//   flush_i         per-requester flush
//   rsp_valid_o     response valid (one-hot or zero)
//   rsp_ready_i     response ready per requester
//   rsp_tag_o       tag of the operation in flight / last operation
//   rsp_timeout_o   response came from a watchdog kill, data invalid
//   unit_start_o    single-cycle start pulse to the lane
//   unit_kill_o     single-cycle abort pulse to the lane
//   unit_sel_o      owner index, steers the lane operand mux
//   unit_ready_i    lane result available (level)
//   busy_o          arbiter not idle
module fpnew_fsm_share_arbiter #(
    parameter int NumReq   = 2,
    parameter int TagWidth = 8,
    parameter int Timeout  = 64,
    localparam int IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    input  logic [NumReq*TagWidth-1:0] req_tag_i,
    input  logic [NumReq-1:0]          flush_i,
    output logic [NumReq-1:0]          rsp_valid_o,
    input  logic [NumReq-1:0]          rsp_ready_i,
    output logic [TagWidth-1:0]        rsp_tag_o,
    output logic                       rsp_timeout_o,
    output logic                       unit_start_o,
    output logic                       unit_kill_o,
    output logic [IdxW-1:0]            unit_sel_o,
    input  logic                       unit_ready_i,
    output logic                       busy_o
);

    localparam int CntW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (Timeout > 0) ? CntW'(Timeout - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t              state;
    logic [IdxW-1:0]     rr_ptr;
    logic [IdxW-1:0]     owner;
    logic [TagWidth-1:0] tag_q;
    logic [CntW-1:0]     cnt;
    logic                to_q;

    logic [TagWidth-1:0] tags [NumReq];
    logic [NumReq-1:0]   eligible;
    logic                found;
    logic [IdxW-1:0]     winner;
    logic                wd_expire;

    for (genvar r = 0; r < NumReq; r++) begin : g_tags
        assign tags[r] = req_tag_i[r*TagWidth +: TagWidth];
    end

    assign eligible  = req_valid_i & ~flush_i;
    assign wd_expire = (Timeout != 0) && (cnt == CntLast);

    // Round-robin search starting at rr_ptr, wrapping past NumReq-1.
    always_comb begin
        int              idx;
        logic [IdxW-1:0] idx_w;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int i = 0; i < NumReq; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            idx_w = IdxW'(idx);
            if (!found && eligible[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    // Handshake outputs are combinational so accept->start and ready->rsp
    // take zero cycles; they are forced low while reset is asserted.
    always_comb begin
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        unit_start_o = 1'b0;
        unit_kill_o  = 1'b0;
        unit_sel_o   = '0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        req_ready_o[winner] = 1'b1;
                        unit_start_o        = 1'b1;
                        unit_sel_o          = winner;
                    end
                end
                BUSY: begin
                    unit_sel_o = owner;
                    // Flush beats a same-cycle result; result beats the watchdog.
                    if (flush_i[owner]) begin
                        unit_kill_o = 1'b1;
                    end else if (unit_ready_i) begin
                        rsp_valid_o[owner] = 1'b1;
                    end else if (wd_expire) begin
                        unit_kill_o = 1'b1;
                    end
                end
                HOLD: begin
                    unit_sel_o = owner;
                    if (!flush_i[owner]) rsp_valid_o[owner] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_tag_o     = tag_q;
    assign rsp_timeout_o = to_q;
    assign busy_o        = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            tag_q  <= '0;
            cnt    <= '0;
            to_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner  <= winner;
                        tag_q  <= tags[winner];
                        cnt    <= '0;
                        to_q   <= 1'b0;
                        rr_ptr <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (flush_i[owner]) begin
                        state <= IDLE;
                    end else if (unit_ready_i) begin
                        state <= rsp_ready_i[owner] ? IDLE : HOLD;
                    end else if (wd_expire) begin
                        to_q  <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush_i[owner] || rsp_ready_i[owner]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpnew_fsm_share_arbiter.sv
// Directed bench for fpnew_fsm_share_arbiter (NumReq=2, TagWidth=8, Timeout=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fpnew_fsm_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_tag;
    logic [1:0]  flush;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_tag;
    logic        rsp_timeout;
    logic        unit_start;
    logic        unit_kill;
    logic [0:0]  unit_sel;
    logic        unit_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    fpnew_fsm_share_arbiter #(
        .NumReq  (2),
        .TagWidth(8),
        .Timeout (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_tag_i    (req_tag),
        .flush_i      (flush),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_tag_o    (rsp_tag),
        .rsp_timeout_o(rsp_timeout),
        .unit_start_o (unit_start),
        .unit_kill_o  (unit_kill),
        .unit_sel_o   (unit_sel),
        .unit_ready_i (unit_ready),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_tag;
        int         g;

        // Reset with both requesters valid
        rst        = 1'b1;
        req_valid  = 2'b11;
        req_tag    = {8'h20, 8'h10};
        flush      = 2'b00;
        rsp_ready  = 2'b00;
        unit_ready = 1'b0;
        nxt();
        nxt();
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_tag", 32'(rsp_tag), 0);
        chk("rst_timeout", 32'(rsp_timeout), 0);
        chk("rst_start", 32'(unit_start), 0);
        chk("rst_kill", 32'(unit_kill), 0);
        chk("rst_sel", 32'(unit_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        #1;
        chk("rel_grant", 32'(req_ready), 1);
        chk("rel_start", 32'(unit_start), 1);
        chk("rel_sel", 32'(unit_sel), 0);

        // Round robin: lane result in the 6th busy cycle, starts 7 cycles apart
        for (int k = 0; k < 3; k++) begin
            g = k % 2;
            if (k > 0) begin
                nxt();
                unit_ready = 1'b0;
                req_tag    = {8'h20 + 8'(k), 8'h10 + 8'(k)};
                #1;
                chk("rr_grant", 32'(req_ready), 32'(1 << g));
                chk("rr_start", 32'(unit_start), 1);
                chk("rr_sel", 32'(unit_sel), 32'(g));
            end
            exp_tag = (g == 0) ? 8'h10 + 8'(k) : 8'h20 + 8'(k);
            for (int c = 1; c <= 5; c++) begin
                nxt();
                #1;
                chk("rr_busy", 32'(busy), 1);
                chk("rr_no_grant", 32'(req_ready), 0);
                chk("rr_no_start", 32'(unit_start), 0);
                chk("rr_no_rsp", 32'(rsp_valid), 0);
            end
            nxt();
            unit_ready = 1'b1;
            rsp_ready  = 2'b11;
            #1;
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << g));
            chk("rr_rsp_tag", 32'(rsp_tag), 32'(exp_tag));
            chk("rr_no_kill", 32'(unit_kill), 0);
        end

        // Backpressure on requester 1
        nxt();
        unit_ready = 1'b0;
        rsp_ready  = 2'b01;
        req_tag    = {8'h5A, 8'h33};
        #1;
        chk("bp_grant", 32'(req_ready), 2);
        chk("bp_sel", 32'(unit_sel), 1);
        for (int c = 1; c <= 5; c++) begin
            nxt();
            #1;
        end
        nxt();
        unit_ready = 1'b1;
        #1;
        chk("bp_rsp_first", 32'(rsp_valid), 2);
        for (int c = 1; c <= 10; c++) begin
            nxt();
            unit_ready = 1'b0;
            #1;
            chk("bp_hold_valid", 32'(rsp_valid), 2);
            chk("bp_hold_tag", 32'(rsp_tag), 32'h5A);
            chk("bp_no_grant", 32'(req_ready), 0);
            chk("bp_no_start", 32'(unit_start), 0);
        end
        nxt();
        rsp_ready = 2'b11;
        #1;
        chk("bp_release_valid", 32'(rsp_valid), 2);
        nxt();
        req_tag = {8'h66, 8'h44};
        #1;
        chk("bp_idle_busy", 32'(busy), 0);
        chk("bp_next_grant", 32'(req_ready), 1);
        chk("bp_next_start", 32'(unit_start), 1);

        // Flush of owner 0 together with lane ready
        nxt();
        #1;
        nxt();
        #1;
        nxt();
        flush      = 2'b01;
        unit_ready = 1'b1;
        #1;
        chk("fl_kill", 32'(unit_kill), 1);
        chk("fl_no_rsp", 32'(rsp_valid), 0);
        nxt();
        flush      = 2'b00;
        unit_ready = 1'b0;
        rsp_ready  = 2'b00;
        req_tag    = {8'h77, 8'h44};
        #1;
        chk("fl_idle", 32'(busy), 0);
        chk("fl_next_grant", 32'(req_ready), 2);
        chk("fl_next_start", 32'(unit_start), 1);
        chk("fl_no_kill", 32'(unit_kill), 0);

        // Watchdog: lane never ready, kill in the 8th busy cycle
        for (int c = 1; c <= 7; c++) begin
            nxt();
            #1;
            chk("wd_no_kill", 32'(unit_kill), 0);
            chk("wd_no_rsp", 32'(rsp_valid), 0);
        end
        nxt();
        #1;
        chk("wd_kill", 32'(unit_kill), 1);
        chk("wd_kill_no_rsp", 32'(rsp_valid), 0);
        for (int c = 1; c <= 3; c++) begin
            nxt();
            #1;
            chk("wd_hold_valid", 32'(rsp_valid), 2);
            chk("wd_hold_timeout", 32'(rsp_timeout), 1);
            chk("wd_hold_tag", 32'(rsp_tag), 32'h77);
            chk("wd_hold_no_kill", 32'(unit_kill), 0);
        end
        nxt();
        rsp_ready = 2'b10;
        #1;
        chk("wd_hs_valid", 32'(rsp_valid), 2);
        nxt();
        rsp_ready = 2'b00;
        req_tag   = {8'h77, 8'h9C};
        #1;
        chk("wd_next_grant", 32'(req_ready), 1);

        // Lane ready on the watchdog expiry cycle: normal response
        for (int c = 1; c <= 7; c++) begin
            nxt();
            #1;
        end
        nxt();
        unit_ready = 1'b1;
        rsp_ready  = 2'b11;
        #1;
        chk("tie_no_kill", 32'(unit_kill), 0);
        chk("tie_rsp_valid", 32'(rsp_valid), 1);
        chk("tie_timeout", 32'(rsp_timeout), 0);
        chk("tie_tag", 32'(rsp_tag), 32'h9C);
        nxt();
        unit_ready = 1'b0;
        rsp_ready  = 2'b00;
        req_tag    = {8'hE1, 8'h9C};
        #1;
        chk("tie_next_grant", 32'(req_ready), 2);

        // Reset while holding a response
        nxt();
        #1;
        nxt();
        unit_ready = 1'b1;
        #1;
        chk("rh_rsp", 32'(rsp_valid), 2);
        nxt();
        unit_ready = 1'b0;
        #1;
        chk("rh_hold", 32'(rsp_valid), 2);
        nxt();
        rst = 1'b1;
        #1;
        chk("rh_rst_no_kill", 32'(unit_kill), 0);
        nxt();
        rst = 1'b0;
        #1;
        chk("rh_after_valid", 32'(rsp_valid), 0);
        chk("rh_after_busy", 32'(busy), 0);
        chk("rh_after_tag", 32'(rsp_tag), 0);
        chk("rh_after_grant", 32'(req_ready), 1);
        chk("rh_after_start", 32'(unit_start), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
